// File: rtl/booth_radix4_seq_mult_if.sv
// Operand/result bundle between the ALU control unit (master) and the
// radix-4 Booth multiplier (slave).
interface booth_radix4_seq_mult_if #(
   parameter int WIDTH = 32
) ();
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_mode, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one digit per clock, exact 2*WIDTH product.
// Optional early termination when the remaining digits are all zero: define BOOTH_EARLY_TERM_EN.
module booth_radix4_seq_mult #(
   parameter int WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   booth_radix4_seq_mult_if.slave    bus
);
   localparam int XW = 2*WIDTH + 2;
   localparam int QW = WIDTH + 2;
   localparam int N  = WIDTH/2 + 1;
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_r;
   logic [XW-1:0]        acc_r;
   logic [XW-1:0]        mc_r;
   logic [QW-1:0]        mq_r;
   logic                 q_m1_r;
   logic [CW-1:0]        count_r;
   logic                 busy_r;
   logic                 done_r;
   logic [2*WIDTH-1:0]   product_r;

   logic [XW-1:0]        acc_nxt_s;
   logic [QW-1:0]        mq_nxt_s;
   logic [XW-1:0]        m_ext_s;
   logic [QW-1:0]        q_ext_s;
   logic                 last_s;
   logic                 finish_s;
`ifdef BOOTH_EARLY_TERM_EN
   logic                 all_eq_s;
`endif

   // Signed multiple of the multiplicand selected by one Booth digit {q1,q0,q_m1}.
   function automatic logic [XW-1:0] booth_addend(input logic [2:0] digit,
                                                  input logic [XW-1:0] mc);
      case (digit)
         3'b001, 3'b010: return mc;
         3'b011:         return mc << 1;
         3'b100:         return (~(mc << 1)) + {{(XW-1){1'b0}}, 1'b1};
         3'b101, 3'b110: return (~mc) + {{(XW-1){1'b0}}, 1'b1};
         default:        return {XW{1'b0}};
      endcase
   endfunction

   // Operand extension, next-step datapath and termination decision.
   always_comb begin
      m_ext_s   = {{(XW-WIDTH){bus.signed_mode & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
      q_ext_s   = {{2{bus.signed_mode & bus.multiplier[WIDTH-1]}}, bus.multiplier};
      acc_nxt_s = acc_r + booth_addend({mq_r[1:0], q_m1_r}, mc_r);
      mq_nxt_s  = {{2{mq_r[QW-1]}}, mq_r[QW-1:2]};
      last_s    = (count_r == CW'(N - 1));
`ifdef BOOTH_EARLY_TERM_EN
      // Remaining bits all equal to the new q_m1 means every later digit is zero.
      all_eq_s  = (mq_nxt_s == {QW{mq_r[1]}});
      finish_s  = last_s | all_eq_s;
`else
      finish_s  = last_s;
`endif
   end

   // Control FSM with registered busy/done/product and the Booth datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         acc_r     <= {XW{1'b0}};
         mc_r      <= {XW{1'b0}};
         mq_r      <= {QW{1'b0}};
         q_m1_r    <= 1'b0;
         count_r   <= {CW{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= {(2*WIDTH){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_r <= ST_RUN;
                  acc_r   <= {XW{1'b0}};
                  mc_r    <= m_ext_s;
                  mq_r    <= q_ext_s;
                  q_m1_r  <= 1'b0;
                  count_r <= {CW{1'b0}};
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               acc_r   <= acc_nxt_s;
               mc_r    <= mc_r << 2;
               mq_r    <= mq_nxt_s;
               q_m1_r  <= mq_r[1];
               count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
               if (finish_s) begin
                  state_r   <= ST_DONE;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  product_r <= acc_nxt_s[2*WIDTH-1:0];
               end else begin
                  state_r <= ST_RUN;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.product = product_r;
endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Scoreboard bench for booth_radix4_seq_mult: driver pushes reference products and
// latencies, an independent monitor pops and compares on every done pulse.
module tb_booth_radix4_seq_mult;
   localparam int W     = 32;
   localparam int NSTEP = W/2 + 1;
`ifdef BOOTH_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [63:0] prod;
      int          issue_cyc;
      int          lat;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   errors;
   int   checks;
   exp_t sb[$];
   logic [63:0] prev_prod;

   booth_radix4_seq_mult_if #(.WIDTH(W)) bus ();

   booth_radix4_seq_mult #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Exact product from plain arithmetic.
   function automatic logic [63:0] ref_mul(input logic sm, input logic [31:0] m,
                                           input logic [31:0] q);
      longint      sa, sb_;
      logic [63:0] ua, ub;
      if (sm) begin
         sa  = longint'($signed(m));
         sb_ = longint'($signed(q));
         return 64'(sa * sb_);
      end
      ua = {32'h0, m};
      ub = {32'h0, q};
      return ua * ub;
   endfunction

   // Number of digit steps: with early termination, the first s >= 1 after which
   // every remaining extended multiplier bit (from bit 2s-1 up) is identical.
   function automatic int exp_steps(input logic sm, input logic [31:0] q);
      logic [33:0] e;
      int          s_et;
      bit          same;
      e    = {{2{sm & q[31]}}, q};
      s_et = NSTEP;
      for (int s = NSTEP - 1; s >= 1; s--) begin
         same = 1'b1;
         for (int b = 2*s - 1; b < 34; b++)
            if (e[b] !== e[33]) same = 1'b0;
         if (same) s_et = s;
      end
      return EARLY ? s_et : NSTEP;
   endfunction

   task automatic issue(input logic sm, input logic [31:0] m, input logic [31:0] q);
      int waited;
      waited = 0;
      @(negedge clk);
      while (bus.busy && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (bus.busy) begin
         errors++;
         $display("FAIL issue_wait busy=%0b required 0 after %0d cycles", bus.busy, waited);
      end
      bus.start        = 1'b1;
      bus.signed_mode  = sm;
      bus.multiplicand = m;
      bus.multiplier   = q;
      sb.push_back('{prod: ref_mul(sm, m, q), issue_cyc: cyc, lat: exp_steps(sm, q) + 1});
      @(negedge clk);
      bus.start        = 1'b0;
      bus.signed_mode  = 1'($urandom);
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners [6];
      corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4000_0000};
      case ($urandom_range(0, 5))
         0:       return corners[$urandom_range(0, 5)];
         1:       return 32'($urandom_range(0, 15));
         2:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: invariants every cycle, scoreboard compare on each done pulse.
   initial begin
      exp_t e;
      prev_prod = 64'h0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_prod = 64'h0;
         end else begin
            checks++;
            if ((bus.busy && bus.done) || (!bus.done && bus.product !== prev_prod)) begin
               errors++;
               $display("FAIL invariant busy=%0b done=%0b product=%h required held %h",
                        bus.busy, bus.done, bus.product, prev_prod);
            end
            if (bus.done) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL spurious_done at cycle %0d, no operation outstanding", cyc);
               end else begin
                  e = sb.pop_front();
                  if (bus.product !== e.prod) begin
                     errors++;
                     $display("FAIL product got %h required %h", bus.product, e.prod);
                  end
                  checks++;
                  if (cyc - e.issue_cyc != e.lat) begin
                     errors++;
                     $display("FAIL latency got %0d required %0d", cyc - e.issue_cyc, e.lat);
                  end
               end
               prev_prod = bus.product;
            end
         end
      end
   end

   initial begin
      int waited;
      errors           = 0;
      checks           = 0;
      cyc              = 0;
      reset_n          = 1'b0;
      bus.start        = 1'b0;
      bus.signed_mode  = 1'b0;
      bus.multiplicand = 32'h0;
      bus.multiplier   = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0) begin
         errors++;
         $display("FAIL reset_state busy=%0b done=%0b product=%h required 0 0 0",
                  bus.busy, bus.done, bus.product);
      end
      reset_n = 1'b1;

      issue(1'b1, 32'h3,         32'hFFFF_FFFC);
      issue(1'b1, 32'h8000_0000, 32'h8000_0000);
      issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(1'b0, 32'h8000_0000, 32'h2);
      issue(1'b1, 32'h5,         32'h1);
      issue(1'b1, 32'h5,         32'hFFFF_FFFF);
      issue(1'b1, 32'h5,         32'h4000_0000);
      issue(1'b0, 32'h7FFF_FFFF, 32'h8000_0000);

      // Start pulse during a run must be ignored; the next op goes in back-to-back.
      issue(1'b1, 32'h7, 32'h4000_0009);
      repeat (3) @(negedge clk);
      bus.start        = 1'b1;
      bus.signed_mode  = 1'b0;
      bus.multiplicand = 32'hDEAD_BEEF;
      bus.multiplier   = 32'h1234_5678;
      @(negedge clk);
      bus.start = 1'b0;
      issue(1'b0, 32'hCAFE_0001, 32'h9000_0003);

      // Reset in the middle of a run aborts it with no product update.
      issue(1'b1, 32'h0000_007B, 32'hA000_0000);
      repeat (7) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0) begin
         errors++;
         $display("FAIL abort_reset busy=%0b done=%0b product=%h required 0 0 0",
                  bus.busy, bus.done, bus.product);
      end
      sb.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      issue(1'b1, 32'hFFFF_CFC7, 32'h0000_1A85);

      for (int i = 0; i < 2000; i++)
         issue(1'($urandom), pick_operand(), pick_operand());

      waited = 0;
      while (sb.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain outstanding=%0d required 0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
